// File: rtl/dmem_fill_controller.sv
// Memset engine sharing the data-memory port with the CPU load/store path.
// The engine writes the fill word only in cycles the CPU leaves the port idle.
module dmem_fill_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [31:0]          i_base_addr,
  input  logic [CNT_WIDTH-1:0] i_word_count,
  input  logic [31:0]          i_fill_value,
  input  logic                 i_cpu_mem_read,
  input  logic                 i_cpu_mem_write,
  input  logic [31:0]          i_cpu_mem_addr,
  input  logic [31:0]          i_cpu_mem_wdata,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [31:0]          o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_words_done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t               r_state;
  logic [31:0]          r_cur_addr;
  logic [31:0]          r_fill_value;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [CNT_WIDTH-1:0] r_words_done;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_slot;

  // The CPU always wins; the engine only takes otherwise idle cycles.
  assign w_slot = (r_state == S_FILL) && !i_cpu_mem_read && !i_cpu_mem_write;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_fill_value <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cur_addr   <= {i_base_addr[31:2], 2'b00};
            r_remaining  <= i_word_count;
            r_fill_value <= i_fill_value;
            r_words_done <= '0;
            if (i_word_count != '0) begin
              r_state <= S_FILL;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_slot) begin
            r_cur_addr   <= r_cur_addr + 32'd4;
            r_remaining  <= r_remaining - 1'b1;
            r_words_done <= r_words_done + 1'b1;
            if (r_remaining == CNT_WIDTH'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    if (w_slot) begin
      o_mem_read  = 1'b0;
      o_mem_write = 1'b1;
      o_mem_addr  = r_cur_addr;
      o_mem_wdata = r_fill_value;
    end else begin
      o_mem_read  = i_cpu_mem_read;
      o_mem_write = i_cpu_mem_write;
      o_mem_addr  = i_cpu_mem_addr;
      o_mem_wdata = i_cpu_mem_wdata;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_words_done = r_words_done;

endmodule

// File: tb/tb_dmem_fill_controller.sv
// Bench for dmem_fill_controller: transaction-level fill model checked every cycle,
// a byte-addressed memory fed from the DUT port, and directed literal checks.
module tb_dmem_fill_controller;

  localparam int CW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [31:0]   i_base_addr;
  logic [CW-1:0] i_word_count;
  logic [31:0]   i_fill_value;
  logic          i_cpu_mem_read;
  logic          i_cpu_mem_write;
  logic [31:0]   i_cpu_mem_addr;
  logic [31:0]   i_cpu_mem_wdata;
  logic          o_mem_read;
  logic          o_mem_write;
  logic [31:0]   o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_words_done;

  dmem_fill_controller #(.CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_word_count(i_word_count), .i_fill_value(i_fill_value),
    .i_cpu_mem_read(i_cpu_mem_read), .i_cpu_mem_write(i_cpu_mem_write),
    .i_cpu_mem_addr(i_cpu_mem_addr), .i_cpu_mem_wdata(i_cpu_mem_wdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_busy(o_busy), .o_done(o_done), .o_words_done(o_words_done)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int done_count = 0;
  int busy_seen = 0;
  logic [7:0] dut_mem [logic [31:0]];

  // Fill-job model: a pending job of m_n words, m_k already written.
  bit          m_active = 0;
  bit          m_done_p = 0;
  int          m_k = 0;
  int          m_n = 0;
  logic [31:0] m_base = '0;
  logic [31:0] m_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      if (dut_mem.exists(a + 32'(i))) w[8*i +: 8] = dut_mem[a + 32'(i)];
      else w[8*i +: 8] = 8'hxx;
    end
    return w;
  endfunction

  always @(negedge i_clk) begin
    bit          slot;
    logic        e_wr, e_rd;
    logic [31:0] e_addr, e_wd;
    if (i_reset) begin
      m_active = 0; m_done_p = 0; m_k = 0;
    end
    slot   = m_active && !i_cpu_mem_read && !i_cpu_mem_write;
    e_wr   = slot | i_cpu_mem_write;
    e_rd   = slot ? 1'b0 : i_cpu_mem_read;
    e_addr = slot ? m_base + (32'(m_k) << 2) : i_cpu_mem_addr;
    e_wd   = slot ? m_val : i_cpu_mem_wdata;
    check("busy", 32'(o_busy), 32'(m_active));
    check("done", 32'(o_done), 32'(m_done_p));
    check("words_done", 32'(o_words_done), 32'(m_k));
    check("mem_write", 32'(o_mem_write), 32'(e_wr));
    check("mem_read", 32'(o_mem_read), 32'(e_rd));
    if (e_wr || e_rd) check("mem_addr", o_mem_addr, e_addr);
    if (e_wr) check("mem_wdata", o_mem_wdata, e_wd);
    if (o_mem_write && !i_reset)
      for (int i = 0; i < 4; i++) dut_mem[o_mem_addr + 32'(i)] = o_mem_wdata[8*i +: 8];
    if (o_done) done_count++;
    if (o_busy) busy_seen++;
    if (!i_reset) begin
      if (m_done_p) m_done_p = 0;
      else if (m_active) begin
        if (slot) begin
          m_k++;
          if (m_k == m_n) begin m_active = 0; m_done_p = 1; end
        end
      end else if (i_start) begin
        m_base = {i_base_addr[31:2], 2'b00};
        m_val  = i_fill_value;
        m_n    = int'(i_word_count);
        m_k    = 0;
        if (m_n == 0) m_done_p = 1; else m_active = 1;
      end
    end
  end

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_cpu();
    i_cpu_mem_read = 0; i_cpu_mem_write = 0; i_cpu_mem_addr = '0; i_cpu_mem_wdata = '0;
  endtask

  // mode: 0 quiet CPU, 1 stores to 100 in cycles 1 and 3, 2 random traffic, 3 stray start at 200
  task automatic run_fill(input logic [31:0] base, input int count, input logic [31:0] val,
                          input int mode, output int lat);
    i_base_addr = base; i_word_count = CW'(count); i_fill_value = val; i_start = 1;
    cycle();
    i_start = 0;
    lat = 1;
    while (1) begin
      clear_cpu();
      if (mode == 1 && (lat == 1 || lat == 3)) begin
        i_cpu_mem_write = 1; i_cpu_mem_addr = 32'd100; i_cpu_mem_wdata = 32'h12345678;
      end else if (mode == 2) begin
        int r = int'($urandom_range(0, 9));
        i_cpu_mem_read  = (r < 2);
        i_cpu_mem_write = (r == 2 || r == 3);
        i_cpu_mem_addr  = 32'($urandom_range(512, 767)) << 2;
        i_cpu_mem_wdata = $urandom();
        i_start = ($urandom_range(0, 9) == 0);
        i_base_addr = $urandom();
        i_word_count = CW'($urandom_range(0, 9));
      end else if (mode == 3) begin
        i_start = (lat == 2);
        i_base_addr = 32'd200; i_word_count = CW'(3);
      end
      if (o_done) break;
      if (lat >= 300) begin
        check("done_timeout", 32'(lat), 32'd0);
        break;
      end
      cycle();
      lat++;
    end
    i_start = 0;
    clear_cpu();
    $display("[TB] fill base=%h count=%0d value=%h latency=%0d words_done=%0d",
             base, count, val, lat, o_words_done);
  endtask

  initial begin
    int lat, dc0;
    logic [31:0] v;
    i_reset = 1; i_start = 0; i_base_addr = '0; i_word_count = '0; i_fill_value = '0;
    clear_cpu();
    i_cpu_mem_read = 1; i_cpu_mem_addr = 32'h1234;
    cycle(); cycle();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_words_done", 32'(o_words_done), 32'd0);
    check("rst_passthru_read", 32'(o_mem_read), 32'd1);
    check("rst_passthru_addr", o_mem_addr, 32'h1234);
    clear_cpu();
    i_reset = 0;
    cycle();

    // Idle fill
    run_fill(32'd8, 4, 32'hDEADBEEF, 0, lat);
    check("idle_latency", 32'(lat), 32'd5);
    check("idle_words_done", 32'(o_words_done), 32'd4);
    for (int a = 8; a < 24; a += 4) check("idle_word", rd_word(32'(a)), 32'hDEADBEEF);
    check("idle_byte8", 32'(dut_mem[32'd8]), 32'h000000ef);
    check("idle_byte11", 32'(dut_mem[32'd11]), 32'h000000de);
    cycle();

    // Contention with two CPU stores
    run_fill(32'd28, 4, 32'h00007FFF, 1, lat);
    check("cont_latency", 32'(lat), 32'd7);
    check("cont_cpu_store", rd_word(32'd100), 32'h12345678);
    for (int a = 28; a < 44; a += 4) check("cont_word", rd_word(32'(a)), 32'h00007FFF);
    check("cont_byte29", 32'(dut_mem[32'd29]), 32'h0000007f);
    cycle();

    // Zero count
    busy_seen = 0;
    run_fill(32'd24, 0, 32'hCAFEF00D, 0, lat);
    check("zero_latency", 32'(lat), 32'd1);
    check("zero_untouched", 32'(dut_mem.exists(32'd24)), 32'd0);
    cycle();
    check("zero_busy_never", 32'(busy_seen), 32'd0);

    // Start while busy is ignored
    dc0 = done_count;
    run_fill(32'd48, 5, 32'h0BADC0DE, 3, lat);
    cycle(); cycle(); cycle();
    check("ign_latency", 32'(lat), 32'd6);
    check("ign_200_untouched", 32'(dut_mem.exists(32'd200)), 32'd0);
    check("ign_done_pulses", 32'(done_count - dc0), 32'd1);
    check("ign_last_word", rd_word(32'd64), 32'h0BADC0DE);

    // Reset mid-fill after three engine writes
    dut_mem.delete();
    i_base_addr = 32'd0; i_word_count = CW'(8); i_fill_value = 32'h11223344; i_start = 1;
    cycle();
    i_start = 0;
    cycle(); cycle(); cycle();
    i_reset = 1;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_words_done", 32'(o_words_done), 32'd0);
    cycle();
    i_reset = 0;
    cycle();
    for (int a = 0; a < 12; a += 4) check("midrst_written", rd_word(32'(a)), 32'h11223344);
    for (int a = 12; a < 32; a += 4) check("midrst_untouched", 32'(dut_mem.exists(32'(a))), 32'd0);
    $display("[TB] reset mid-fill: 3 words written before reset");
    run_fill(32'd0, 8, 32'h55667788, 0, lat);
    check("postrst_latency", 32'(lat), 32'd9);
    check("postrst_word7", rd_word(32'd28), 32'h55667788);
    cycle();

    // Unaligned base and address wrap
    dut_mem.delete();
    run_fill(32'hFFFFFFFE, 2, 32'hA5A55A5A, 0, lat);
    check("wrap_latency", 32'(lat), 32'd3);
    check("wrap_word_hi", rd_word(32'hFFFFFFFC), 32'hA5A55A5A);
    check("wrap_word_lo", rd_word(32'h00000000), 32'hA5A55A5A);
    check("wrap_no_fffffffe_word", 32'(dut_mem.exists(32'h00000004)), 32'd0);
    cycle();

    // Randomized fills with CPU traffic and stray starts
    for (int t = 0; t < 25; t++) begin
      v = $urandom();
      run_fill($urandom(), int'($urandom_range(0, 12)), v, 2, lat);
      cycle();
      repeat ($urandom_range(0, 2)) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
